// File: rtl/key_input_pkg.sv
// Shared constants for the memory-mapped key/switch input port:
// register byte offsets inside the window and the press counter width.
package key_input_pkg;

    // Width of the PRESS_CNT register (zero-extended on read)
    localparam int PRESS_CNT_W = 16;

    // Size of the decoded register window in bytes
    localparam int WINDOW_BYTES = 32;

    // Byte offsets of the registers inside the window
    localparam logic [4:0] OFF_LEVEL = 5'h00;
    localparam logic [4:0] OFF_RISE  = 5'h04;
    localparam logic [4:0] OFF_MASK  = 5'h08;
    localparam logic [4:0] OFF_CNT   = 5'h0C;
    localparam logic [4:0] OFF_FALL  = 5'h10;

    // Drops the byte-lane bits so any byte address hits its word
    localparam logic [4:0] WORD_MASK = 5'h1C;

endpackage

// File: rtl/key_input_port_debounce.sv
// Companion package for the key input port debounce cell.
// The debounce logic itself is implemented in key_debounce.sv.
package key_input_port_debounce_pkg;
    localparam int UNUSED_ALIAS = 0;
endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer followed by a debounce
// counter that accepts a new level after DEBOUNCE_CYCLES stable cycles.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   key    - raw asynchronous key level
//   level  - debounced level (registered)
//   accept - high in the cycle the debounced level is about to change
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic accept
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // The counter only ever runs while the synchronized input disagrees
    // with the accepted level, so reaching CNT_MAX means the input has
    // been stable at the new value for DEBOUNCE_CYCLES edges.
    assign accept = (sync_b != level) && (count == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            count  <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            if (sync_b == level) begin
                count <= '0;
            end else if (accept) begin
                level <= sync_b;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_input_port.sv
// Memory-mapped key/switch input port: debounced LEVEL, sticky RISE
// (write-1-to-clear), interrupt MASK and a 16-bit PRESS_CNT, with a
// level interrupt. Optional FALL register when KEY_FALL_EDGE_EN is
// defined (offset 0x10); without it that offset reads 0.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   keys               - raw bouncing key levels
//   dm_addr/wena/wdata - CPU data bus request
//   dm_rdata           - combinational read data (0 outside window)
//   dm_sel             - address falls inside the register window
//   irq                - level interrupt request
module key_input_port
    import key_input_pkg::*;
#(
    parameter int          NUM_KEYS        = 16,
    parameter int          DEBOUNCE_CYCLES = 10000,
    parameter logic [31:0] BASE_ADDR       = 32'h1001_F000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [31:0]         dm_addr,
    input  logic                dm_wena,
    input  logic [31:0]         dm_wdata,
    output logic [31:0]         dm_rdata,
    output logic                dm_sel,
    output logic                irq
);

    logic [NUM_KEYS-1:0]    level;
    logic [NUM_KEYS-1:0]    accept;
    logic [NUM_KEYS-1:0]    rise;
    logic [NUM_KEYS-1:0]    rise_set;
    logic [NUM_KEYS-1:0]    mask;
    logic [NUM_KEYS-1:0]    clr_bits;
    logic [PRESS_CNT_W-1:0] press_cnt;
    logic [PRESS_CNT_W-1:0] press_next;
    logic [31:0]            offset;
    logic [4:0]             reg_off;
    logic                   wr;
    logic                   wr_rise;
    logic                   wr_mask;
    logic                   wr_cnt;
    logic                   unused_wdata;

    // ---------------------------------------------------------------
    // Per-key synchronizer and debounce
    // ---------------------------------------------------------------
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .key   (keys[g]),
            .level (level[g]),
            .accept(accept[g])
        );
    end

    // A key rises when its accepted change is from 0 to 1
    assign rise_set = accept & ~level;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    // Subtracting the base keeps the window correct for any
    // word-aligned base, not only 32-byte aligned ones.
    assign offset  = dm_addr - BASE_ADDR;
    assign dm_sel  = offset < 32'(WINDOW_BYTES);
    assign reg_off = offset[4:0] & WORD_MASK;

    assign wr      = dm_wena && dm_sel;
    assign wr_rise = wr && (reg_off == OFF_RISE);
    assign wr_mask = wr && (reg_off == OFF_MASK);
    assign wr_cnt  = wr && (reg_off == OFF_CNT);

    assign clr_bits     = dm_wdata[NUM_KEYS-1:0];
    assign unused_wdata = ^dm_wdata;

    // ---------------------------------------------------------------
    // Press counter: a new rise wins over a clearing write and then
    // counts as the first press after the clear.
    // ---------------------------------------------------------------
    always_comb begin
        press_next = press_cnt;
        if (|rise_set) begin
            if (wr_cnt) begin
                press_next = PRESS_CNT_W'(1);
            end else begin
                press_next = press_cnt + PRESS_CNT_W'(1);
            end
        end else if (wr_cnt) begin
            press_next = '0;
        end
    end

    // ---------------------------------------------------------------
    // RISE, MASK, PRESS_CNT state
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise      <= '0;
            mask      <= '0;
            press_cnt <= '0;
        end else begin
            if (wr_rise) begin
                rise <= (rise & ~clr_bits) | rise_set;
            end else begin
                rise <= rise | rise_set;
            end
            if (wr_mask) begin
                mask <= dm_wdata[NUM_KEYS-1:0];
            end
            press_cnt <= press_next;
        end
    end

`ifdef KEY_FALL_EDGE_EN
    logic [NUM_KEYS-1:0] fall;
    logic [NUM_KEYS-1:0] fall_set;
    logic                wr_fall;

    assign fall_set = accept & level;
    assign wr_fall  = wr && (reg_off == OFF_FALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall <= '0;
        end else if (wr_fall) begin
            fall <= (fall & ~clr_bits) | fall_set;
        end else begin
            fall <= fall | fall_set;
        end
    end

    assign irq = |((rise | fall) & mask);
`else
    assign irq = |(rise & mask);
`endif

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        dm_rdata = '0;
        if (dm_sel) begin
            case (reg_off)
                OFF_LEVEL: dm_rdata = 32'(level);
                OFF_RISE:  dm_rdata = 32'(rise);
                OFF_MASK:  dm_rdata = 32'(mask);
                OFF_CNT:   dm_rdata = 32'(press_cnt);
`ifdef KEY_FALL_EDGE_EN
                OFF_FALL:  dm_rdata = 32'(fall);
`endif
                default:   dm_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_key_input_port.sv
// Self-checking bench for key_input_port (NUM_KEYS=16,
// DEBOUNCE_CYCLES=4): directed sequences, a read-decode table and a
// randomized run against a sliding-window reference model.
module tb_key_input_port;

    localparam int          NK   = 16;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = 32'h1001_F000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic [31:0] dm_addr;
    logic        dm_wena;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_sel;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_level, m_rise, m_fall, m_mask, m_cnt;
    logic [15:0] hist[$];

    typedef struct {
        logic [31:0] addr;
        logic        sel;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t     tbl[12];
    logic [5:0]  offs[8];

    always #5 clk = ~clk;

    key_input_port #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .keys    (keys),
        .dm_addr (dm_addr),
        .dm_wena (dm_wena),
        .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .dm_sel  (dm_sel),
        .irq     (irq)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_reg(input string name, input logic [5:0] off,
                           input logic [31:0] exp);
        dm_wena = 1'b0;
        dm_addr = BASE + 32'(off);
        #1;
        chk(name, dm_rdata, exp);
    endtask

    function automatic void model_reset();
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_mask  = '0;
        m_cnt   = '0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(16'h0);
    endfunction

    // A key's level becomes v once the DB samples that have made it
    // through the 2-cycle synchronizer all equal v.
    task automatic model_edge();
        logic [15:0] newl, rs, fs;
        logic [31:0] off;
        logic [4:0]  ro;
        logic        hit;
        int          ones;
        if (reset) begin
            model_reset();
            return;
        end
        hist.push_back(keys);
        while (hist.size() > DB + 2) void'(hist.pop_front());
        newl = m_level;
        for (int i = 0; i < NK; i++) begin
            ones = 0;
            for (int j = 0; j < DB; j++) ones += int'(hist[j][i]);
            if (ones == DB) newl[i] = 1'b1;
            else if (ones == 0) newl[i] = 1'b0;
        end
        rs  = newl & ~m_level;
        fs  = ~newl & m_level;
        off = dm_addr - BASE;
        hit = dm_wena && (off < 32);
        ro  = off[4:0] & 5'h1C;
        if (hit && ro == 5'h04) m_rise = m_rise & ~dm_wdata[15:0];
        m_rise = m_rise | rs;
        if (hit && ro == 5'h10) m_fall = m_fall & ~dm_wdata[15:0];
        m_fall = m_fall | fs;
        if (hit && ro == 5'h08) m_mask = dm_wdata[15:0];
        if (rs != 0) m_cnt = (hit && ro == 5'h0C) ? 16'd1 : m_cnt + 16'd1;
        else if (hit && ro == 5'h0C) m_cnt = 16'd0;
        m_level = newl;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] data);
        dm_wena  = 1'b1;
        dm_addr  = BASE + 32'(off);
        dm_wdata = data;
        step();
        dm_wena  = 1'b0;
    endtask

    task automatic check_model();
        logic [15:0] f;
`ifdef KEY_FALL_EDGE_EN
        f = m_fall;
`else
        f = 16'h0;
`endif
        chk_reg("m_level", 6'h00, {16'h0, m_level});
        chk_reg("m_rise",  6'h04, {16'h0, m_rise});
        chk_reg("m_mask",  6'h08, {16'h0, m_mask});
        chk_reg("m_cnt",   6'h0C, {16'h0, m_cnt});
        chk_reg("m_fall",  6'h10, {16'h0, f});
        chk("m_irq", {31'h0, irq}, {31'h0, |((m_rise | f) & m_mask)});
    endtask

    initial begin
        tbl[0]  = '{BASE + 32'h00, 1'b1, 32'h8};
        tbl[1]  = '{BASE + 32'h03, 1'b1, 32'h8};
        tbl[2]  = '{BASE + 32'h04, 1'b1, 32'h8};
        tbl[3]  = '{BASE + 32'h06, 1'b1, 32'h8};
        tbl[4]  = '{BASE + 32'h08, 1'b1, 32'h8};
        tbl[5]  = '{BASE + 32'h0C, 1'b1, 32'h1};
        tbl[6]  = '{BASE + 32'h10, 1'b1, 32'h0};
        tbl[7]  = '{BASE + 32'h14, 1'b1, 32'h0};
        tbl[8]  = '{BASE + 32'h1F, 1'b1, 32'h0};
        tbl[9]  = '{BASE + 32'h20, 1'b0, 32'h0};
        tbl[10] = '{BASE - 32'h04, 1'b0, 32'h0};
        tbl[11] = '{32'h0000_0000, 1'b0, 32'h0};
        offs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h1C, 6'h20};

        keys     = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_wena  = 1'b0;
        reset    = 1'b1;
        model_reset();
        steps(2);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        step();
        chk_reg("rst_level", 6'h00, 32'h0);
        chk_reg("rst_rise",  6'h04, 32'h0);
        chk_reg("rst_mask",  6'h08, 32'h0);
        chk_reg("rst_cnt",   6'h0C, 32'h0);

        // 3-cycle glitch on key 3 never reaches LEVEL
        keys = 16'h0008;
        steps(3);
        keys = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_reg("glitch_level", 6'h00, 32'h0);
        end
        chk_reg("glitch_rise", 6'h04, 32'h0);
        chk_reg("glitch_cnt",  6'h0C, 32'h0);

        // key 3 held: LEVEL changes exactly 6 cycles later
        keys = 16'h0008;
        steps(5);
        chk_reg("hold_early", 6'h00, 32'h0);
        step();
        chk_reg("hold_level", 6'h00, 32'h8);
        chk_reg("hold_rise",  6'h04, 32'h8);
        chk_reg("hold_cnt",   6'h0C, 32'h1);

        wr(6'h08, 32'h8);
        chk("irq_set", {31'h0, irq}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            step();
            dm_addr = tbl[i].addr;
            #1;
            chk($sformatf("tbl%0d_sel", i), {31'h0, dm_sel}, {31'h0, tbl[i].sel});
            chk($sformatf("tbl%0d_data", i), dm_rdata, tbl[i].data);
        end

        wr(6'h04, 32'h8);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        chk_reg("w1c_rise", 6'h04, 32'h0);

        // W1C of bit 0 on the very edge key 0 is accepted
        keys = 16'h0009;
        steps(5);
        wr(6'h04, 32'h1);
        chk_reg("setwin_rise", 6'h04, 32'h1);
        chk_reg("setwin_cnt",  6'h0C, 32'h2);

        // PRESS_CNT write on a rise edge loads 1
        keys = 16'h0029;
        steps(5);
        wr(6'h0C, 32'hDEAD);
        chk_reg("cntwr_cnt",  6'h0C, 32'h1);
        chk_reg("cntwr_rise", 6'h04, 32'h21);

        // counter wrap from a forced 0xFFFF
        force dut.press_cnt = 16'hFFFF;
        step();
        release dut.press_cnt;
        m_cnt = 16'hFFFF;
        chk_reg("wrap_pre", 6'h0C, 32'hFFFF);
        keys = 16'h00A9;
        steps(6);
        chk_reg("wrap_cnt", 6'h0C, 32'h0);
        dm_addr = BASE + 32'h20;
        #1;
        chk("oow_sel",   {31'h0, dm_sel}, 32'h0);
        chk("oow_rdata", dm_rdata, 32'h0);

        // reset in the middle of a debounce with every key high
        wr(6'h08, 32'hFFFF);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        keys = 16'hFFFF;
        steps(3);
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        chk_reg("mid_rst_level", 6'h00, 32'h0);
        chk_reg("mid_rst_rise",  6'h04, 32'h0);
        chk_reg("mid_rst_mask",  6'h08, 32'h0);
        chk_reg("mid_rst_cnt",   6'h0C, 32'h0);
        steps(2);
        reset = 1'b0;
        steps(5);
        chk_reg("post_rst_early", 6'h04, 32'h0);
        step();
        chk_reg("post_rst_rise",  6'h04, 32'hFFFF);
        chk_reg("post_rst_level", 6'h00, 32'hFFFF);
        chk_reg("post_rst_cnt",   6'h0C, 32'h1);

        // randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NK; i++)
                if ($urandom_range(0, 5) == 0) keys[i] = ~keys[i];
            if ($urandom_range(0, 9) < 3) begin
                dm_wena  = 1'b1;
                dm_addr  = BASE + 32'(offs[$urandom_range(0, 7)])
                         + 32'($urandom_range(0, 3));
                dm_wdata = $urandom();
            end else begin
                dm_wena = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            step();
            dm_wena = 1'b0;
            reset   = 1'b0;
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
